// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req_valid/imem_req_addr : fetch request (fetch -> memory)
//   imem_req_ready               : memory accepts the request this cycle
//   imem_rsp_valid/imem_rsp_data : response for the single in-flight request
interface fetch_stage_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Holds the PC, issues one outstanding request at a time to instruction memory,
// buffers one response while decode is stalled, and flushes on redirect.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem            : instruction-memory bus (master side)
//   stall           : decode cannot accept; IF/ID holds
//   redirect_valid  : taken branch/jump; redirect_pc is the target (bits [1:0] ignored)
//   if_id_valid/pc/instr : IF/ID slot towards decode / execute
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      imem,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_id_valid,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_instr
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] inflight_pc, inflight_pc_n;
  logic [31:0] hold_buf, hold_buf_n;
  logic        discard, discard_n;
  logic        ifv_n;
  logic [31:0] ifpc_n, ifinstr_n;

  assign imem.imem_req_valid = (state == S_REQ);
  assign imem.imem_req_addr  = {pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      inflight_pc <= 32'h0;
      hold_buf    <= 32'h0;
      discard     <= 1'b0;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP_INSTR;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      inflight_pc <= inflight_pc_n;
      hold_buf    <= hold_buf_n;
      discard     <= discard_n;
      if_id_valid <= ifv_n;
      if_id_pc    <= ifpc_n;
      if_id_instr <= ifinstr_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    inflight_pc_n = inflight_pc;
    hold_buf_n    = hold_buf;
    discard_n     = discard;
    ifv_n         = if_id_valid;
    ifpc_n        = if_id_pc;
    ifinstr_n     = if_id_instr;

    // Unstalled decode consumes the slot; refill below if something arrives.
    if (!stall) begin
      ifv_n     = 1'b0;
      ifinstr_n = NOP_INSTR;
    end

    unique case (state)
      S_REQ: begin
        if (imem.imem_req_ready) begin
          inflight_pc_n = pc;
          pc_n          = pc + 32'd4;
          state_n       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else if (!stall) begin
            ifv_n     = 1'b1;
            ifpc_n    = inflight_pc;
            ifinstr_n = imem.imem_rsp_data;
            state_n   = S_REQ;
          end else begin
            hold_buf_n = imem.imem_rsp_data;
            state_n    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          ifv_n     = 1'b1;
          ifpc_n    = inflight_pc;
          ifinstr_n = hold_buf;
          state_n   = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase

    // Redirect overrides everything computed above.
    if (redirect_valid) begin
      pc_n          = {redirect_pc[31:2], 2'b00};
      inflight_pc_n = inflight_pc;
      hold_buf_n    = hold_buf;
      ifv_n         = 1'b0;
      ifpc_n        = if_id_pc;
      ifinstr_n     = NOP_INSTR;
      unique case (state)
        S_REQ: begin
          // A request accepted this cycle still gets a response; mark it stale.
          if (imem.imem_req_ready) begin
            state_n   = S_WAIT;
            discard_n = 1'b1;
          end else begin
            state_n   = S_REQ;
            discard_n = discard;
          end
        end
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            state_n   = S_REQ;
            discard_n = 1'b0;
          end else begin
            state_n   = S_WAIT;
            discard_n = 1'b1;
          end
        end
        default: begin
          state_n   = S_REQ;
          discard_n = discard;
        end
      endcase
    end
  end

endmodule
